// File: rtl/usb2_ts_packer.sv
// Packs a byte-wide MPEG-TS stream into 188-byte aligned packets for the EP3 isochronous IN buffer.
// Define USB2_TS_PACKER_STATS_EN to add saturating drop/commit statistics counters.
module usb2_ts_packer #(
  parameter int unsigned PKTS_PER_XFER = 5,
  parameter logic [15:0] FLUSH_TIMEOUT = 16'd50000,
  parameter logic [7:0]  TS_SYNC       = 8'h47
) (
  input  logic        ep3_ext_clk,
  input  logic        reset_n,
  input  logic        stream_en,
  input  logic [7:0]  ts_data,
  input  logic        ts_valid,
  input  logic        ts_sop,
  output logic        ts_ready,
  output logic [10:0] buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  input  logic        buf_in_ready,
  output logic        buf_in_commit,
  output logic [10:0] buf_in_commit_len,
  input  logic        buf_in_commit_ack,
  output logic        sync_err
`ifdef USB2_TS_PACKER_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_drop_cnt,
  output logic [15:0] stat_commit_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ACKLOW = 2'd3
  } state_t;

  localparam logic [2:0] LAST_PKT = 3'(PKTS_PER_XFER - 1);

  state_t      state_r;
  logic [2:0]  pkt_cnt_r;
  logic [7:0]  byte_cnt_r;
  logic [15:0] idle_cnt_r;
  logic        accept_s;
  logic        sop_ok_s;
  logic        timeout_s;
  logic [10:0] base_addr_s;

  function automatic logic [10:0] pkt_base(input logic [2:0] pkts);
    return {8'd0, pkts} * 11'd188;
  endfunction

  // Handshake and event decode from registered state and current inputs
  always_comb begin
    ts_ready    = (state_r == ST_FILL) && buf_in_ready && stream_en;
    accept_s    = ts_valid && ts_ready;
    sop_ok_s    = ts_sop && (ts_data == TS_SYNC);
    timeout_s   = (FLUSH_TIMEOUT != 16'd0) && (idle_cnt_r == FLUSH_TIMEOUT) && (pkt_cnt_r != 3'd0);
    base_addr_s = pkt_base(pkt_cnt_r);
  end

  // Packing state machine, write path and commit handshake
  always_ff @(posedge ep3_ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= ST_IDLE;
      pkt_cnt_r         <= 3'd0;
      byte_cnt_r        <= 8'd0;
      idle_cnt_r        <= 16'd0;
      buf_in_addr       <= 11'd0;
      buf_in_data       <= 8'd0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= 11'd0;
      sync_err          <= 1'b0;
    end else begin
      buf_in_wren <= 1'b0;
      sync_err    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (stream_en && buf_in_ready) state_r <= ST_FILL;
          else                           state_r <= ST_IDLE;
        end
        ST_FILL: begin
          if (!stream_en) begin
            pkt_cnt_r  <= 3'd0;
            byte_cnt_r <= 8'd0;
            idle_cnt_r <= 16'd0;
            state_r    <= ST_IDLE;
          end else if (accept_s) begin
            idle_cnt_r <= 16'd0;
            if (sop_ok_s) begin
              // A valid sync byte always restarts the current packet slot
              buf_in_wren <= 1'b1;
              buf_in_addr <= base_addr_s;
              buf_in_data <= ts_data;
              byte_cnt_r  <= 8'd1;
              sync_err    <= (byte_cnt_r != 8'd0);
            end else if (byte_cnt_r == 8'd0) begin
              sync_err <= 1'b1;
            end else begin
              buf_in_wren <= 1'b1;
              buf_in_addr <= base_addr_s + {3'd0, byte_cnt_r};
              buf_in_data <= ts_data;
              if (byte_cnt_r == 8'd187) begin
                byte_cnt_r <= 8'd0;
                pkt_cnt_r  <= pkt_cnt_r + 3'd1;
                if (pkt_cnt_r == LAST_PKT) state_r <= ST_COMMIT;
                else                       state_r <= ST_FILL;
              end else begin
                byte_cnt_r <= byte_cnt_r + 8'd1;
              end
            end
          end else if (timeout_s) begin
            sync_err   <= (byte_cnt_r != 8'd0);
            byte_cnt_r <= 8'd0;
            state_r    <= ST_COMMIT;
          end else if (idle_cnt_r != FLUSH_TIMEOUT) begin
            idle_cnt_r <= idle_cnt_r + 16'd1;
          end else begin
            idle_cnt_r <= idle_cnt_r;
          end
        end
        ST_COMMIT: begin
          if (!buf_in_commit) begin
            buf_in_commit     <= 1'b1;
            buf_in_commit_len <= base_addr_s;
          end else if (buf_in_commit_ack) begin
            buf_in_commit <= 1'b0;
            state_r       <= ST_ACKLOW;
          end else begin
            state_r <= ST_COMMIT;
          end
        end
        ST_ACKLOW: begin
          if (!buf_in_commit_ack) begin
            pkt_cnt_r  <= 3'd0;
            byte_cnt_r <= 8'd0;
            idle_cnt_r <= 16'd0;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_ACKLOW;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef USB2_TS_PACKER_STATS_EN
  // Saturating statistics: dropped bytes/packets and completed commit handshakes
  always_ff @(posedge ep3_ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_drop_cnt   <= 16'd0;
      stat_commit_cnt <= 16'd0;
    end else if (stat_clr) begin
      stat_drop_cnt   <= 16'd0;
      stat_commit_cnt <= 16'd0;
    end else begin
      if (sync_err && (stat_drop_cnt != 16'hFFFF)) stat_drop_cnt <= stat_drop_cnt + 16'd1;
      else                                          stat_drop_cnt <= stat_drop_cnt;
      if ((state_r == ST_COMMIT) && buf_in_commit && buf_in_commit_ack && (stat_commit_cnt != 16'hFFFF))
        stat_commit_cnt <= stat_commit_cnt + 16'd1;
      else
        stat_commit_cnt <= stat_commit_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_usb2_ts_packer.sv
// Self-checking bench for usb2_ts_packer: directed scenarios plus randomized traffic against a packet-level model.
module tb_usb2_ts_packer;

  localparam int M_PKTS = 5;
  localparam int M_FT   = 50000;
  localparam int M_SYNC = 8'h47;
  localparam int PH_IDLE = 0, PH_FILL = 1, PH_COMMIT = 2, PH_ACKLOW = 3;

  logic        ep3_ext_clk = 1'b0;
  logic        reset_n, stream_en, ts_valid, ts_sop, buf_in_ready, buf_in_commit_ack;
  logic [7:0]  ts_data;
  logic        ts_ready, buf_in_wren, buf_in_commit, sync_err;
  logic [10:0] buf_in_addr, buf_in_commit_len;
  logic [7:0]  buf_in_data;

  always #5 ep3_ext_clk = ~ep3_ext_clk;

  usb2_ts_packer dut (
    .ep3_ext_clk       (ep3_ext_clk),
    .reset_n           (reset_n),
    .stream_en         (stream_en),
    .ts_data           (ts_data),
    .ts_valid          (ts_valid),
    .ts_sop            (ts_sop),
    .ts_ready          (ts_ready),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .sync_err          (sync_err)
  );

  int checks = 0, errors = 0;
  // model: phase, complete packets stored, position inside current packet, idle cycles
  int m_phase, m_pkts, m_pos, m_idle;
  bit m_acc;
  int e_wren, e_addr, e_data, e_sync, e_commit, e_len;
  // ack policy and randomization control
  int c_age, ack_dly, ack_hold, hold_left;
  bit rnd;
  // observations of the DUT for literal pins
  int n_wren, n_sync, n_commit_cyc, n_ready, first_addr, first_data, last_addr, last_len, restart_addr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (m_phase == PH_FILL) && buf_in_ready && stream_en;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_pkts = 0; m_pos = 0; m_idle = 0;
    e_wren = 0; e_addr = 0; e_data = 0; e_sync = 0; e_commit = 0; e_len = 0;
  endtask

  task automatic model_store();
    e_wren = 1;
    e_addr = m_pkts * 188 + m_pos;
    e_data = ts_data;
    m_pos++;
    if (m_pos == 188) begin
      m_pos = 0;
      m_pkts++;
      if (m_pkts == M_PKTS) m_phase = PH_COMMIT;
    end
  endtask

  // Advance the model over one clock edge using the inputs presented now
  task automatic model_step();
    bit good;
    e_wren = 0; e_sync = 0;
    m_acc = ts_valid && m_ready();
    case (m_phase)
      PH_IDLE: if (stream_en && buf_in_ready) m_phase = PH_FILL;
      PH_FILL: begin
        if (!stream_en) begin
          m_pkts = 0; m_pos = 0; m_idle = 0; m_phase = PH_IDLE;
        end else if (m_acc) begin
          m_idle = 0;
          good = ts_sop && (ts_data == M_SYNC);
          if (good) begin
            e_sync = (m_pos != 0);
            m_pos = 0;
            model_store();
          end else if (m_pos == 0) e_sync = 1;
          else model_store();
        end else if (m_idle == M_FT && m_pkts > 0) begin
          e_sync = (m_pos != 0);
          m_pos = 0;
          m_phase = PH_COMMIT;
        end else if (m_idle < M_FT) m_idle++;
      end
      PH_COMMIT: begin
        if (!e_commit) begin
          e_commit = 1; e_len = m_pkts * 188;
        end else if (buf_in_commit_ack) begin
          e_commit = 0; m_phase = PH_ACKLOW;
        end
      end
      default: if (!buf_in_commit_ack) begin
        m_pkts = 0; m_pos = 0; m_idle = 0; m_phase = PH_IDLE;
      end
    endcase
  endtask

  // One clock: drive ack, check ts_ready, step model, check registered outputs
  task automatic cycle();
    if (e_commit) begin
      c_age++;
      buf_in_commit_ack = (c_age > ack_dly);
      if (buf_in_commit_ack) hold_left = ack_hold;
    end else begin
      c_age = 0;
      if (hold_left > 0 && buf_in_commit_ack) hold_left--;
      else buf_in_commit_ack = 1'b0;
    end
    #1;
    chk("ts_ready", ts_ready, m_ready());
    if (ts_ready) n_ready++;
    model_step();
    @(negedge ep3_ext_clk);
    chk("wren", buf_in_wren, e_wren);
    chk("sync_err", sync_err, e_sync);
    chk("commit", buf_in_commit, e_commit);
    if (e_wren) begin
      chk("addr", buf_in_addr, e_addr);
      chk("data", buf_in_data, e_data);
    end
    if (e_commit) chk("commit_len", buf_in_commit_len, e_len);
    if (buf_in_wren) begin
      if (n_wren == 0) begin first_addr = buf_in_addr; first_data = buf_in_data; end
      if (n_wren == 100) restart_addr = buf_in_addr;
      last_addr = buf_in_addr;
      n_wren++;
    end
    if (sync_err) n_sync++;
    if (buf_in_commit) begin n_commit_cyc++; last_len = buf_in_commit_len; end
  endtask

  task automatic clear_obs();
    n_wren = 0; n_sync = 0; n_commit_cyc = 0; n_ready = 0;
    first_addr = -1; first_data = -1; last_addr = -1; last_len = 0; restart_addr = -1;
  endtask

  task automatic idle(input int n);
    ts_valid = 1'b0; ts_sop = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rnd) buf_in_ready = ($urandom_range(0, 9) != 0);
      cycle();
    end
  endtask

  task automatic send_byte(input bit sop, input logic [7:0] d);
    int guard = 0;
    if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    ts_valid = 1'b1; ts_sop = sop; ts_data = d;
    do begin
      if (rnd) buf_in_ready = ($urandom_range(0, 9) != 0);
      cycle();
      guard++;
    end while (!m_acc && guard < 3000);
    if (!m_acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=%0d cycles expected=acceptance", guard);
    end
    ts_valid = 1'b0; ts_sop = 1'b0;
  endtask

  task automatic send_pkt(input int len);
    send_byte(1'b1, 8'h47);
    for (int i = 1; i < len; i++) begin
      if (rnd) send_byte(1'b0, 8'($urandom));
      else     send_byte(1'b0, i[7:0]);
    end
  endtask

  initial begin
    int guard;
    int r;
    reset_n = 1'b0; stream_en = 1'b0; ts_valid = 1'b0; ts_sop = 1'b0; ts_data = 8'h00;
    buf_in_ready = 1'b0; buf_in_commit_ack = 1'b0;
    c_age = 0; ack_dly = 3; ack_hold = 0; hold_left = 0; rnd = 1'b0;
    model_reset();
    clear_obs();
    repeat (2) @(negedge ep3_ext_clk);
    chk("rst_ts_ready", ts_ready, 0);
    chk("rst_wren", buf_in_wren, 0);
    chk("rst_commit", buf_in_commit, 0);
    chk("rst_commit_len", buf_in_commit_len, 0);
    chk("rst_addr", buf_in_addr, 0);
    chk("rst_sync_err", sync_err, 0);
    reset_n = 1'b1; stream_en = 1'b1; buf_in_ready = 1'b1;

    // five clean packets, ack three cycles after commit rises
    for (int p = 0; p < 5; p++) send_pkt(188);
    idle(12);
    chk("t1_wren_cnt", n_wren, 940);
    chk("t1_first_addr", first_addr, 0);
    chk("t1_last_addr", last_addr, 939);
    chk("t1_commit_len", last_len, 940);
    chk("t1_commit_cycles", n_commit_cyc, 4);
    chk("t1_sync_cnt", n_sync, 0);

    // two packets then idle timeout flush
    clear_obs(); ack_dly = 1;
    for (int p = 0; p < 2; p++) send_pkt(188);
    idle(50010);
    chk("t2_commit_len", last_len, 376);
    chk("t2_wren_cnt", n_wren, 376);
    chk("t2_sync_cnt", n_sync, 0);

    // packet interrupted at byte 100 by a new sync
    clear_obs(); ack_dly = 2;
    send_pkt(100);
    for (int p = 0; p < 5; p++) send_pkt(188);
    idle(20);
    chk("t3_sync_cnt", n_sync, 1);
    chk("t3_restart_addr", restart_addr, 0);
    chk("t3_wren_cnt", n_wren, 1040);
    chk("t3_commit_len", last_len, 940);

    // stream joined mid-packet: 30 bytes without sop
    clear_obs();
    for (int i = 0; i < 30; i++) send_byte(1'b0, 8'($urandom));
    for (int p = 0; p < 5; p++) send_pkt(188);
    idle(20);
    chk("t4_sync_cnt", n_sync, 30);
    chk("t4_first_addr", first_addr, 0);
    chk("t4_first_data", first_data, 8'h47);
    chk("t4_wren_cnt", n_wren, 940);

    // backpressure from the buffer, then stream_en drop after 3 packets
    clear_obs();
    buf_in_ready = 1'b0; ts_valid = 1'b1; ts_sop = 1'b1; ts_data = 8'h47;
    repeat (10) cycle();
    chk("t5_ready_while_busy", n_ready, 0);
    chk("t5_wren_while_busy", n_wren, 0);
    buf_in_ready = 1'b1;
    for (int p = 0; p < 3; p++) send_pkt(188);
    stream_en = 1'b0;
    idle(5);
    stream_en = 1'b1;
    chk("t5_no_commit", n_commit_cyc, 0);
    chk("t5_wren_cnt", n_wren, 564);
    clear_obs();
    for (int p = 0; p < 5; p++) send_pkt(188);
    idle(20);
    chk("t5_first_addr", first_addr, 0);
    chk("t5_commit_len", last_len, 940);

    // asynchronous reset in the middle of a commit
    clear_obs(); ack_dly = 5;
    for (int p = 0; p < 5; p++) send_pkt(188);
    guard = 0;
    while (!e_commit && guard < 50) begin cycle(); guard++; end
    chk("t6_commit_reached", buf_in_commit, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_commit", buf_in_commit, 0);
    chk("t6_rst_wren", buf_in_wren, 0);
    chk("t6_rst_ready", ts_ready, 0);
    model_reset();
    buf_in_commit_ack = 1'b0; c_age = 0; hold_left = 0;
    @(negedge ep3_ext_clk);
    reset_n = 1'b1;
    clear_obs();
    for (int p = 0; p < 5; p++) send_pkt(188);
    idle(20);
    chk("t6_first_addr", first_addr, 0);
    chk("t6_commit_len", last_len, 940);

    // randomized traffic: stalls, garbage, truncated packets, ack timing
    rnd = 1'b1;
    for (int ev = 0; ev < 80; ev++) begin
      ack_dly = $urandom_range(0, 5);
      ack_hold = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r == 0)      send_byte(1'b0, 8'($urandom));
      else if (r == 1) send_pkt($urandom_range(1, 187));
      else if (r == 2) idle($urandom_range(1, 40));
      else             send_pkt(188);
    end
    rnd = 1'b0; buf_in_ready = 1'b1;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
